mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-indexed data memory.
- Converts MIPS byte addresses into word indices, checks alignment, and sequences the memory's one-cycle registered read.
- Performs read-modify-write for sub-word stores, and does lane extraction plus sign/zero extension for loads.
- Always drives the memory with full-word accesses and stalls the pipeline while a transaction is in flight.

Parameters:
- DEPTH, 32, number of 32-bit words in data memory.
- IDX_W, $clog2(DEPTH), width of the significant word-index bits.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_Req_valid  in  1  request present from EX/MEM.
- o_Req_ready  out  1  unit idle; request accepted when valid & ready at a rising edge.
- i_Addr  in  32  byte address.
- i_Wdata  in  32  store data; sub-word data is in the low bits.
- i_MemRead  in  1  load request.
- i_MemWrite  in  1  store request.
- i_Long  in  2  access size: 00 byte, 01 half, 10/11 word.
- i_MemSign  in  1  1 = sign-extend load, 0 = zero-extend.
- o_Mem_addr  out  32  word index, {0, addr[IDX_W+1:2]}.
- o_Mem_wdata  out  32  full word to write.
- o_MemRead  out  1  memory read strobe.
- o_MemWrite  out  1  memory write strobe.
- o_Mem_long  out  2  constant 2'b11.
- o_Mem_sign  out  1  constant 0.
- i_Mem_rdata  in  32  memory read data, valid the cycle after the o_MemRead edge.
- o_Load_data  out  32  extended load result.
- o_Load_valid  out  1  one-cycle pulse.
- o_Stall  out  1  equals ~o_Req_ready.
- o_AddrErr  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset: state IDLE; o_Load_data=0, o_Load_valid=0, o_AddrErr=0, o_MemRead=0, o_MemWrite=0, o_Mem_wdata=0, o_Mem_addr=0.
- Reset mid-transaction aborts it. No strobe is issued in the cycle after reset. The merge buffer is discarded.
- Acceptance: at the accepting edge, the unit latches addr, wdata, long, sign and op into request registers.
- Error checks at acceptance:
  - Half-word access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - i_MemRead & i_MemWrite both set is an error.
  - On any of these: o_AddrErr pulses the next cycle, no memory strobe is issued, and the unit stays in IDLE.
- Valid with neither read nor write asserted is ignored.
- FSM states: IDLE, RD, RESP, MERGE, WR.
- Load path: IDLE -> RD -> RESP -> IDLE.
  - RD: o_MemRead=1, o_Mem_addr=index.
  - RESP: select lane = addr[1:0]*8 (byte) or addr[1]*16 (half); extend per sign; register into o_Load_data.
  - o_Load_valid is high the cycle after RESP. Total latency is 3 cycles from the accept edge to the o_Load_valid cycle.
- Word store path: IDLE -> WR -> IDLE. In WR: o_MemWrite=1, o_Mem_wdata=wdata.
- Sub-word store path: IDLE -> RD -> MERGE -> WR -> IDLE.
  - MERGE replaces the addressed byte or half lane of i_Mem_rdata with wdata[7:0] or wdata[15:0].
  - Other lanes are preserved bit-exact.
- o_Req_ready is high only in IDLE. A new request may be accepted on the edge that leaves WR or RESP for IDLE only after returning to IDLE, i.e. there is no back-to-back overlap.
- o_MemRead and o_MemWrite are never high in the same cycle.
- Index out of range (addr[31:IDX_W+2]!=0) truncates, so the index wraps mod DEPTH.

Optional Feature:
- Macro: MEM_BOUND_CHECK_EN.
- Defined: a nonzero addr[31:IDX_W+2] is rejected like a misalignment (o_AddrErr pulse, no access).
- Undefined: upper bits are ignored and the index wraps modulo DEPTH.

Decomposition:
- Shared package mem_pkg:
  - Size encodings LONG_BYTE=2'b00, LONG_HALF=2'b01, LONG_WORD=2'b11.
  - State enum (IDLE, RD, RESP, MERGE, WR).
  - DEPTH default.
- Sub-module lane_mux: purely combinational. Performs load extract/extend and store merge given offset, size and sign. It is reused by both paths.

Test Plan:
- Load byte: mem[3]=32'h80FF_1234, LB addr 0x0F with sign=1 -> o_Load_data=32'hFFFF_FF80, valid 3 cycles after accept. The same load with sign=0 -> 32'h0000_0080.
- Store half: mem[2]=32'hAABB_CCDD, SH addr 0x0A with wdata=32'h1234_5678 -> mem[2]=32'h5678_CCDD. The sequence is one RD strobe then one WR strobe, never both in the same cycle.
- Store word: SW addr 0x04 with wdata=32'hDEAD_BEEF -> mem[1]=32'hDEAD_BEEF after a single WR cycle with no read.
- Misalignment: LW addr 0x06 and LH addr 0x05 -> o_AddrErr pulses, no strobe, o_Req_ready high again the next cycle.
- Reset in MERGE: i_rst asserted during a sub-word store -> no WR strobe, memory unchanged, outputs at reset values.
- Range: SW addr 0x84 with DEPTH=32 -> with MEM_BOUND_CHECK_EN, o_AddrErr pulses; without it, mem[1] is written.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg - shared definitions for the memory access unit slice.
//   DEPTH_DEFAULT : default number of 32-bit words in the data memory
//   LONG_*        : access size encodings carried on i_Long / o_Mem_long
//   state_e       : sequencing states of mem_access_unit
package mem_pkg;

  localparam int DEPTH_DEFAULT = 32;

  localparam logic [1:0] LONG_BYTE = 2'b00;
  localparam logic [1:0] LONG_HALF = 2'b01;
  localparam logic [1:0] LONG_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RESP,
    MERGE,
    WR
  } state_e;

  // Both 2'b10 and 2'b11 encode a full-word access.
  function automatic logic is_word(input logic [1:0] long_i);
    return long_i[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// lane_mux - combinational lane steering shared by the load and store paths.
//   offset    : byte offset within the word (addr[1:0])
//   size      : access size, LONG_BYTE / LONG_HALF / word
//   sign      : 1 = sign-extend the extracted lane on loads
//   word_in   : full word read from memory
//   wdata     : store data, sub-word data in the low bits
//   load_out  : extracted and extended load result
//   merge_out : word_in with the addressed lane replaced by wdata
module lane_mux (
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_out,
  output logic [31:0] merge_out
);
  import mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    // Half-word lanes are selected by addr[1]; addr[0] is known zero here.
    half_sel = offset[1] ? word_in[31:16] : word_in[15:0];

    load_out  = word_in;
    merge_out = word_in;
    if (size == LONG_BYTE) begin
      load_out = {{24{sign & byte_sel[7]}}, byte_sel};
      unique case (offset)
        2'd0:    merge_out[7:0]   = wdata[7:0];
        2'd1:    merge_out[15:8]  = wdata[7:0];
        2'd2:    merge_out[23:16] = wdata[7:0];
        default: merge_out[31:24] = wdata[7:0];
      endcase
    end else if (size == LONG_HALF) begin
      load_out = {{16{sign & half_sel[15]}}, half_sel};
      if (offset[1]) begin
        merge_out[31:16] = wdata[15:0];
      end else begin
        merge_out[15:0] = wdata[15:0];
      end
    end else begin
      load_out  = word_in;
      merge_out = wdata;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit - bridges EX/MEM byte-addressed loads/stores to a
// word-indexed data memory with a one-cycle registered read.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_Req_valid/o_Req_ready : request handshake (ready only when idle)
//   i_Addr, i_Wdata, i_MemRead, i_MemWrite, i_Long, i_MemSign : request
//   o_Mem_*             : full-word memory port (index, data, strobes)
//   i_Mem_rdata         : memory read data, valid the cycle after a read strobe
//   o_Load_data/o_Load_valid : extended load result and its one-cycle pulse
//   o_Stall             : pipeline stall while a transaction is in flight
//   o_AddrErr           : one-cycle pulse on a rejected request
// Optional feature macro: MEM_BOUND_CHECK_EN - when defined, addresses with
// nonzero bits above the word index are rejected instead of wrapping.
module mem_access_unit #(
  parameter int DEPTH = mem_pkg::DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_Req_valid,
  output logic        o_Req_ready,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Wdata,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [1:0]  i_Long,
  input  logic        i_MemSign,
  output logic [31:0] o_Mem_addr,
  output logic [31:0] o_Mem_wdata,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic [1:0]  o_Mem_long,
  output logic        o_Mem_sign,
  input  logic [31:0] i_Mem_rdata,
  output logic [31:0] o_Load_data,
  output logic        o_Load_valid,
  output logic        o_Stall,
  output logic        o_AddrErr
);
  import mem_pkg::*;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         long_q, long_d;
  logic               sign_q, sign_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               addr_err_q, addr_err_d;

  logic [31-IDX_W-2:0] addr_hi;
  logic               range_err;
  logic               misaligned;
  logic               req_err;
  logic [31:0]        lane_load;
  logic [31:0]        lane_merge;

  assign addr_hi = i_Addr[31:IDX_W+2];

`ifdef MEM_BOUND_CHECK_EN
  assign range_err = |addr_hi;
`else
  // Upper address bits are dropped so the index wraps modulo DEPTH.
  logic addr_hi_unused;
  assign addr_hi_unused = |addr_hi;
  assign range_err      = 1'b0;
`endif

  assign misaligned = ((i_Long == LONG_HALF) && i_Addr[0]) ||
                      (is_word(i_Long) && (i_Addr[1:0] != 2'b00));
  assign req_err    = misaligned || range_err || (i_MemRead && i_MemWrite);

  lane_mux u_lane_mux (
    .offset   (off_q),
    .size     (long_q),
    .sign     (sign_q),
    .word_in  (i_Mem_rdata),
    .wdata    (wdata_q),
    .load_out (lane_load),
    .merge_out(lane_merge)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    off_d        = off_q;
    long_d       = long_q;
    sign_d       = sign_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    addr_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_Req_valid && (i_MemRead || i_MemWrite)) begin
          idx_d   = i_Addr[IDX_W+1:2];
          off_d   = i_Addr[1:0];
          long_d  = i_Long;
          sign_d  = i_MemSign;
          write_d = i_MemWrite;
          wdata_d = i_Wdata;
          if (req_err) begin
            addr_err_d = 1'b1;
          end else if (i_MemWrite && is_word(i_Long)) begin
            // Full-word stores need no read-modify-write.
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = i_Wdata;
          end else begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: begin
        state_d = write_q ? MERGE : RESP;
      end
      RESP: begin
        load_data_d  = lane_load;
        load_valid_d = 1'b1;
        state_d      = IDLE;
      end
      MERGE: begin
        mem_wdata_d = lane_merge;
        mem_write_d = 1'b1;
        state_d     = WR;
      end
      WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      off_q        <= '0;
      long_q       <= '0;
      sign_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      long_q       <= long_d;
      sign_q       <= sign_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign o_Req_ready  = (state_q == IDLE);
  assign o_Stall      = ~o_Req_ready;
  assign o_Mem_addr   = {{(32-IDX_W){1'b0}}, idx_q};
  assign o_Mem_wdata  = mem_wdata_q;
  assign o_MemRead    = mem_read_q;
  assign o_MemWrite   = mem_write_q;
  assign o_Mem_long   = LONG_WORD;
  assign o_Mem_sign   = 1'b0;
  assign o_Load_data  = load_data_q;
  assign o_Load_valid = load_valid_q;
  assign o_AddrErr    = addr_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit - directed self-checking bench for mem_access_unit.
// Contains a behavioural 32-word memory with a one-cycle registered read.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_Req_valid;
  logic        o_Req_ready;
  logic [31:0] i_Addr;
  logic [31:0] i_Wdata;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [1:0]  i_Long;
  logic        i_MemSign;
  logic [31:0] o_Mem_addr;
  logic [31:0] o_Mem_wdata;
  logic        o_MemRead;
  logic        o_MemWrite;
  logic [1:0]  o_Mem_long;
  logic        o_Mem_sign;
  logic [31:0] i_Mem_rdata;
  logic [31:0] o_Load_data;
  logic        o_Load_valid;
  logic        o_Stall;
  logic        o_AddrErr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          rd_base;
  int          wr_base;

  always #5 i_clk = ~i_clk;

  mem_access_unit dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_Req_valid (i_Req_valid),
    .o_Req_ready (o_Req_ready),
    .i_Addr      (i_Addr),
    .i_Wdata     (i_Wdata),
    .i_MemRead   (i_MemRead),
    .i_MemWrite  (i_MemWrite),
    .i_Long      (i_Long),
    .i_MemSign   (i_MemSign),
    .o_Mem_addr  (o_Mem_addr),
    .o_Mem_wdata (o_Mem_wdata),
    .o_MemRead   (o_MemRead),
    .o_MemWrite  (o_MemWrite),
    .o_Mem_long  (o_Mem_long),
    .o_Mem_sign  (o_Mem_sign),
    .i_Mem_rdata (i_Mem_rdata),
    .o_Load_data (o_Load_data),
    .o_Load_valid(o_Load_valid),
    .o_Stall     (o_Stall),
    .o_AddrErr   (o_AddrErr)
  );

  // Behavioural data memory plus strobe counters.
  always @(posedge i_clk) begin
    if (i_rst) begin
      i_Mem_rdata <= '0;
    end else if (o_MemRead) begin
      i_Mem_rdata <= mem[o_Mem_addr[4:0]];
    end
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (o_MemWrite) begin
      mem[o_Mem_addr[4:0]] <= o_Mem_wdata;
    end
    if (o_MemRead)  rd_cnt   <= rd_cnt + 1;
    if (o_MemWrite) wr_cnt   <= wr_cnt + 1;
    if (o_MemRead && o_MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setMem(input logic [4:0] idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge i_clk);
    pre_en  = 1'b0;
  endtask

  // Presents a request for one accepting edge; returns at the negedge after it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rd, input logic wr,
                               input logic [1:0] long_v, input logic sign);
    i_Req_valid = 1'b1;
    i_Addr      = addr;
    i_Wdata     = wdata;
    i_MemRead   = rd;
    i_MemWrite  = wr;
    i_Long      = long_v;
    i_MemSign   = sign;
    @(negedge i_clk);
    i_Req_valid = 1'b0;
    i_MemRead   = 1'b0;
    i_MemWrite  = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_Req_valid = 1'b0;
    i_Addr      = '0;
    i_Wdata     = '0;
    i_MemRead   = 1'b0;
    i_MemWrite  = 1'b0;
    i_Long      = 2'b00;
    i_MemSign   = 1'b0;
    repeat (2) @(negedge i_clk);

    checkOutput("rst_ready",      {31'd0, o_Req_ready},  32'd1);
    checkOutput("rst_stall",      {31'd0, o_Stall},      32'd0);
    checkOutput("rst_load_data",  o_Load_data,           32'd0);
    checkOutput("rst_load_valid", {31'd0, o_Load_valid}, 32'd0);
    checkOutput("rst_addr_err",   {31'd0, o_AddrErr},    32'd0);
    checkOutput("rst_memread",    {31'd0, o_MemRead},    32'd0);
    checkOutput("rst_memwrite",   {31'd0, o_MemWrite},   32'd0);
    checkOutput("rst_mem_wdata",  o_Mem_wdata,           32'd0);
    checkOutput("rst_mem_addr",   o_Mem_addr,            32'd0);
    checkOutput("mem_long",       {30'd0, o_Mem_long},   32'd3);
    checkOutput("mem_sign",       {31'd0, o_Mem_sign},   32'd0);

    i_rst = 1'b0;
    setMem(5'd1, 32'h0000_0000);
    setMem(5'd2, 32'hAABB_CCDD);
    setMem(5'd3, 32'h80FF_1234);
    setMem(5'd5, 32'h1122_3344);
    @(negedge i_clk);

    // LB 0x0F signed: RD, RESP, then valid cycle.
    rd_base = rd_cnt;
    applyStimulus(32'h0000_000F, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("lb_rd_strobe",   {31'd0, o_MemRead},    32'd1);
    checkOutput("lb_rd_addr",     o_Mem_addr,            32'd3);
    checkOutput("lb_stall",       {31'd0, o_Stall},      32'd1);
    checkOutput("lb_ready_busy",  {31'd0, o_Req_ready},  32'd0);
    checkOutput("lb_valid_early1",{31'd0, o_Load_valid}, 32'd0);
    @(negedge i_clk);
    checkOutput("lb_resp_nord",   {31'd0, o_MemRead},    32'd0);
    checkOutput("lb_valid_early2",{31'd0, o_Load_valid}, 32'd0);
    @(negedge i_clk);
    checkOutput("lb_valid",       {31'd0, o_Load_valid}, 32'd1);
    checkOutput("lb_signed",      o_Load_data,           32'hFFFF_FF80);
    checkOutput("lb_ready_again", {31'd0, o_Req_ready},  32'd1);
    @(negedge i_clk);
    checkOutput("lb_valid_pulse", {31'd0, o_Load_valid}, 32'd0);
    checkOutput("lb_rd_count",    rd_cnt - rd_base,      32'd1);

    // LB 0x0F unsigned.
    applyStimulus(32'h0000_000F, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge i_clk);
    checkOutput("lbu_valid",      {31'd0, o_Load_valid}, 32'd1);
    checkOutput("lbu_data",       o_Load_data,           32'h0000_0080);

    // SH 0x0A: read, merge, write of upper half.
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    applyStimulus(32'h0000_000A, 32'h1234_5678, 1'b0, 1'b1, 2'b01, 1'b0);
    checkOutput("sh_rd_strobe",   {31'd0, o_MemRead},    32'd1);
    checkOutput("sh_rd_nowrite",  {31'd0, o_MemWrite},   32'd0);
    @(negedge i_clk);
    checkOutput("sh_merge_idle",  {30'd0, o_MemRead, o_MemWrite}, 32'd0);
    @(negedge i_clk);
    checkOutput("sh_wr_strobe",   {31'd0, o_MemWrite},   32'd1);
    checkOutput("sh_wr_noread",   {31'd0, o_MemRead},    32'd0);
    checkOutput("sh_wr_data",     o_Mem_wdata,           32'h5678_CCDD);
    checkOutput("sh_wr_addr",     o_Mem_addr,            32'd2);
    @(negedge i_clk);
    checkOutput("sh_mem2",        mem[2],                32'h5678_CCDD);
    checkOutput("sh_rd_count",    rd_cnt - rd_base,      32'd1);
    checkOutput("sh_wr_count",    wr_cnt - wr_base,      32'd1);
    checkOutput("sh_ready",       {31'd0, o_Req_ready},  32'd1);

    // LH 0x08 signed picks the lower half of mem[2].
    applyStimulus(32'h0000_0008, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
    repeat (2) @(negedge i_clk);
    checkOutput("lh_signed",      o_Load_data,           32'hFFFF_CCDD);

    // LW 0x08.
    applyStimulus(32'h0000_0008, 32'h0, 1'b1, 1'b0, 2'b11, 1'b1);
    repeat (2) @(negedge i_clk);
    checkOutput("lw_data",        o_Load_data,           32'h5678_CCDD);

    // SB 0x0D replaces byte 1 of mem[3] only.
    applyStimulus(32'h0000_000D, 32'hFFFF_FFEE, 1'b0, 1'b1, 2'b00, 1'b0);
    repeat (3) @(negedge i_clk);
    checkOutput("sb_mem3",        mem[3],                32'h80FF_EE34);

    // SW 0x04: single write, no read.
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    applyStimulus(32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0);
    checkOutput("sw_wr_strobe",   {31'd0, o_MemWrite},   32'd1);
    checkOutput("sw_wr_data",     o_Mem_wdata,           32'hDEAD_BEEF);
    checkOutput("sw_wr_addr",     o_Mem_addr,            32'd1);
    @(negedge i_clk);
    checkOutput("sw_mem1",        mem[1],                32'hDEAD_BEEF);
    checkOutput("sw_rd_count",    rd_cnt - rd_base,      32'd0);
    checkOutput("sw_wr_count",    wr_cnt - wr_base,      32'd1);
    checkOutput("sw_ready",       {31'd0, o_Req_ready},  32'd1);

    // Misaligned LW 0x06 and LH 0x05, then read+write together.
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    applyStimulus(32'h0000_0006, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    checkOutput("lw_mis_err",     {31'd0, o_AddrErr},    32'd1);
    checkOutput("lw_mis_ready",   {31'd0, o_Req_ready},  32'd1);
    @(negedge i_clk);
    checkOutput("lw_mis_pulse",   {31'd0, o_AddrErr},    32'd0);
    applyStimulus(32'h0000_0005, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
    checkOutput("lh_mis_err",     {31'd0, o_AddrErr},    32'd1);
    checkOutput("lh_mis_ready",   {31'd0, o_Req_ready},  32'd1);
    @(negedge i_clk);
    applyStimulus(32'h0000_0004, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0);
    checkOutput("rw_both_err",    {31'd0, o_AddrErr},    32'd1);
    @(negedge i_clk);
    applyStimulus(32'h0000_0004, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
    checkOutput("noop_no_err",    {31'd0, o_AddrErr},    32'd0);
    checkOutput("noop_ready",     {31'd0, o_Req_ready},  32'd1);
    @(negedge i_clk);
    checkOutput("err_rd_count",   rd_cnt - rd_base,      32'd0);
    checkOutput("err_wr_count",   wr_cnt - wr_base,      32'd0);

    // Reset while in MERGE of an SB to 0x15 aborts the write.
    wr_base = wr_cnt;
    applyStimulus(32'h0000_0015, 32'h0000_00AA, 1'b0, 1'b1, 2'b00, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("rstm_nowrite",   {31'd0, o_MemWrite},   32'd0);
    checkOutput("rstm_ready",     {31'd0, o_Req_ready},  32'd1);
    checkOutput("rstm_wdata",     o_Mem_wdata,           32'd0);
    checkOutput("rstm_addr",      o_Mem_addr,            32'd0);
    checkOutput("rstm_load_data", o_Load_data,           32'd0);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("rstm_wr_count",  wr_cnt - wr_base,      32'd0);
    checkOutput("rstm_mem5",      mem[5],                32'h1122_3344);

    // SW 0x84: out of range for 32 words.
    applyStimulus(32'h0000_0084, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b11, 1'b0);
`ifdef MEM_BOUND_CHECK_EN
    checkOutput("range_err",      {31'd0, o_AddrErr},    32'd1);
    @(negedge i_clk);
    checkOutput("range_mem1",     mem[1],                32'hDEAD_BEEF);
`else
    checkOutput("range_no_err",   {31'd0, o_AddrErr},    32'd0);
    checkOutput("range_wr_addr",  o_Mem_addr,            32'd1);
    @(negedge i_clk);
    checkOutput("range_mem1",     mem[1],                32'hCAFE_F00D);
`endif

    checkOutput("never_both",     both_cnt,              32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
